// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART receive types and oversampling constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int         OVERSAMPLE = 8;
    localparam logic [2:0] MID_TICK   = 3'd3;
    localparam logic [2:0] LAST_TICK  = 3'(OVERSAMPLE - 1);

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync
// Description : STAGES-deep flop synchroniser for an asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8x-oversampled UART receiver with valid/ready output register.
//               Define UART_RX_PARITY_EN to add the parity bit and par_err.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ce_8,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
    ,
    input  logic                 parity_odd,
    output logic                 par_err
`endif
);

    localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic                 w_rxd_s;
    logic [2:0]           r_tick_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 w_tick_last;
    logic                 w_stop_sample;
    logic                 w_can_load;

    uart_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rxd_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_async (rxd),
        .o_sync  (w_rxd_s)
    );

    assign w_tick_last   = ce_8 && (r_tick_cnt == LAST_TICK);
    assign w_stop_sample = w_tick_last && (r_state == STOP);
    assign w_can_load    = !m_valid || m_ready;
    assign rx_busy       = (r_state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (ce_8) begin
            case (r_state)
                IDLE:    if (!w_rxd_s) w_state_next = START;
                START:   if (r_tick_cnt == MID_TICK) w_state_next = w_rxd_s ? IDLE : DATA;
                DATA: begin
                    if (w_tick_last && (r_bit_cnt == c_LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY:  if (w_tick_last) w_state_next = STOP;
`endif
                STOP:    if (w_tick_last) w_state_next = w_rxd_s ? IDLE : BREAK;
                BREAK:   if (w_rxd_s) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Ticks restart at the start-bit decision so every later sample lands at tick 7.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
        end else if (ce_8) begin
            if ((r_state == IDLE) || ((r_state == START) && (r_tick_cnt == MID_TICK))) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 3'd1;
            end
            if ((r_state == DATA) && (r_tick_cnt == LAST_TICK)) begin
                r_shreg <= {w_rxd_s, r_shreg[DATA_BITS-1:1]};
                if (r_bit_cnt != c_LAST_BIT) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_par_bit <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            if (w_tick_last && (r_state == PARITY)) begin
                r_par_bit <= w_rxd_s;
            end
            par_err <= w_stop_sample && (r_par_bit != ((^r_shreg) ^ parity_odd));
        end
    end
`endif

    // A word arriving while the previous one is still unread is dropped, not queued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_data      <= '0;
            m_valid     <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= w_stop_sample && !w_rxd_s;
            overrun_err <= w_stop_sample && w_rxd_s && !w_can_load;
            if (w_stop_sample && w_rxd_s && w_can_load) begin
                m_data  <= r_shreg;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Self-checking bench for uart_rx_core (8 data bits, ce_8 every
//               4 clocks); parity cases build with UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int DATA_BITS = 8;
    localparam int BIT_STEPS = 32;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Edge seen after 2 sync flops, caught at the next ce (clock 4); mid start 4 ticks on.
    localparam int c_FIRST_SAMPLE = 20 + BIT_STEPS;
    localparam int c_STOP_SAMPLE  = c_FIRST_SAMPLE + BIT_STEPS * (DATA_BITS + PAR);

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        bit         deliver;
        int         ferr;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       ce_8;
    logic       rxd;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd;
    logic       par_err;
`endif

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   ferr_cnt = 0;
    int   ovr_cnt  = 0;
    int   ce_phase = 3;
    logic mon_pv;
    logic mon_pr;
    exp_t mon_e;

    uart_rx_core #(
        .DATA_BITS   (DATA_BITS),
        .SYNC_STAGES (2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ce_8        (ce_8),
        .rxd         (rxd),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_odd  (parity_odd),
        .par_err     (par_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        ce_phase = (ce_phase + 1) % 4;
        ce_8     = (ce_phase == 0);
    endtask

    function automatic logic good_par(input logic [7:0] d);
`ifdef UART_RX_PARITY_EN
        return (^d) ^ parity_odd;
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: a word is new when m_valid is high after an edge where the register was empty or accepted.
    always @(posedge clock) begin
        mon_pv = m_valid;
        mon_pr = m_ready;
        #1;
        if (reset_n) begin
            if (frame_err)   ferr_cnt++;
            if (overrun_err) ovr_cnt++;
            if (m_valid && (!mon_pv || mon_pr)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", m_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("word_data", 32'(m_data), 32'(mon_e.data));
`ifdef UART_RX_PARITY_EN
                    check("par_err", 32'(par_err), 32'(mon_e.perr));
`endif
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_bit,
                              input int extra_low, input int ready_step, input int rst_step);
        logic bits [11];
        int   n;
        bit   aborted;
        n       = 10 + PAR;
        aborted = 1'b0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        if (PAR == 1) bits[9] = par_bit;
        bits[n-1] = stop;
        while (ce_phase != 3) step();
        for (int k = 0; (k < n * BIT_STEPS + extra_low) && !aborted; k++) begin
            step();
            rxd = ((k / BIT_STEPS) < n) ? bits[k / BIT_STEPS] : 1'b0;
            if (k == ready_step) m_ready = 1'b1;
            if (k == ready_step + 1) begin
                m_ready = 1'b0;
                check("b2b_valid", 32'(m_valid), 32'd1);
                check("b2b_data", 32'(m_data), 32'(data));
            end
            if (k == rst_step) begin
                reset_n = 1'b0;
                #1;
                check("rst_m_valid", 32'(m_valid), 32'd0);
                check("rst_m_data", 32'(m_data), 32'd0);
                check("rst_busy", 32'(rx_busy), 32'd0);
                check("rst_frame_err", 32'(frame_err), 32'd0);
                check("rst_overrun", 32'(overrun_err), 32'd0);
                step();
                reset_n = 1'b1;
                rxd     = 1'b1;
                aborted = 1'b1;
            end
        end
        rxd = 1'b1;
        repeat (2 * BIT_STEPS) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [5];
        int   f0;
        int   o0;

        reset_n = 1'b0;
        rxd     = 1'b1;
        ce_8    = 1'b0;
        m_ready = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) step();
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_m_data", 32'(m_data), 32'd0);
        check("reset_busy", 32'(rx_busy), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun", 32'(overrun_err), 32'd0);
        reset_n = 1'b1;
        repeat (10) step();

        tbl[0] = '{data: 8'h00, stop: 1'b1, deliver: 1'b1, ferr: 0};
        tbl[1] = '{data: 8'hFF, stop: 1'b1, deliver: 1'b1, ferr: 0};
        tbl[2] = '{data: 8'h55, stop: 1'b1, deliver: 1'b1, ferr: 0};
        tbl[3] = '{data: 8'h96, stop: 1'b0, deliver: 1'b0, ferr: 1};
        tbl[4] = '{data: 8'h01, stop: 1'b1, deliver: 1'b1, ferr: 0};
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            f0 = ferr_cnt;
            if (tbl[i].deliver) sb_q.push_back('{data: tbl[i].data, perr: 1'b0});
            send_frame(tbl[i].data, tbl[i].stop, good_par(tbl[i].data), 0, -5, -5);
            check("tbl_frame_err", 32'(ferr_cnt - f0), 32'(tbl[i].ferr));
            check("tbl_drained", 32'(sb_q.size()), 32'd0);
        end

        // Word held until the consumer pulses ready.
        m_ready = 1'b0;
        sb_q.push_back('{data: 8'hA5, perr: 1'b0});
        send_frame(8'hA5, 1'b1, good_par(8'hA5), 0, -5, -5);
        repeat (20) step();
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'hA5);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("accept_clears", 32'(m_valid), 32'd0);

        // False start: two ticks low.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        while (ce_phase != 3) step();
        for (int k = 0; k < 40; k++) begin
            step();
            rxd = (k < 8) ? 1'b0 : 1'b1;
            if (k == 16) check("false_start_busy", 32'(rx_busy), 32'd1);
            if (k == 24) check("false_start_idle", 32'(rx_busy), 32'd0);
        end
        repeat (BIT_STEPS * 12) step();
        check("false_start_no_err", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);

        // Bad stop with line held low, then recovery.
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, good_par(8'h3C), 80, -5, -5);
        check("break_one_frame_err", 32'(ferr_cnt - f0), 32'd1);
        check("break_no_valid", 32'(m_valid), 32'd0);
        sb_q.push_back('{data: 8'h81, perr: 1'b0});
        send_frame(8'h81, 1'b1, good_par(8'h81), 0, -5, -5);
        check("after_break_data", 32'(m_data), 32'h81);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Overrun, then back-to-back accept-and-load.
        o0 = ovr_cnt;
        sb_q.push_back('{data: 8'h11, perr: 1'b0});
        send_frame(8'h11, 1'b1, good_par(8'h11), 0, -5, -5);
        send_frame(8'h22, 1'b1, good_par(8'h22), 0, -5, -5);
        check("overrun_once", 32'(ovr_cnt - o0), 32'd1);
        check("overrun_keeps_data", 32'(m_data), 32'h11);
        check("overrun_keeps_valid", 32'(m_valid), 32'd1);
        sb_q.push_back('{data: 8'h22, perr: 1'b0});
        send_frame(8'h22, 1'b1, good_par(8'h22), 0, c_STOP_SAMPLE, -5);
        check("b2b_no_overrun", 32'(ovr_cnt - o0), 32'd1);

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        m_ready    = 1'b1;
        sb_q.push_back('{data: 8'h07, perr: 1'b1});
        send_frame(8'h07, 1'b1, 1'b0, 0, -5, -5);
        sb_q.push_back('{data: 8'h07, perr: 1'b0});
        send_frame(8'h07, 1'b1, 1'b1, 0, -5, -5);
        m_ready = 1'b0;
`endif

        // Reset during data bit 4 while a word is still held.
        send_frame(8'hC3, 1'b1, good_par(8'hC3), 0, -5, BIT_STEPS * 5 + 10);
        m_ready = 1'b1;
        sb_q.push_back('{data: 8'h5A, perr: 1'b0});
        send_frame(8'h5A, 1'b1, good_par(8'h5A), 0, -5, -5);
        check("post_reset_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
